gpio_mulpop: RTL and testbench

Memory-mapped GPIO-emulator peripheral with a parametrised sequential shift-add multiplier and popcount engine. It replaces edge-triggered strobe handling with fully synchronous bus strobes and a busy/done handshake. It also adds a readable high-product word and an operation counter. The block sits behind the SYKT GPIO address window and is driven by the kernel-module bus model.

---
 rtl/gpio_mulpop_if.sv | 24 ++
 rtl/gpio_mulpop.sv | 180 ++++++++++++++++++
 tb/tb_gpio_mulpop.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_mulpop_if.sv
// Bus and GPIO signal bundle between the kernel-module bus model and gpio_mulpop.
interface gpio_mulpop_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       saddress;
    logic              swr;
    logic              srd;
    logic [DATA_W-1:0] sdata_in;
    logic [DATA_W-1:0] sdata_out;
    logic [DATA_W-1:0] gpio_in;
    logic              gpio_latch;
    logic [DATA_W-1:0] gpio_out;
    logic [DATA_W-1:0] gpio_in_s_insp;

    modport master (
        output saddress, swr, srd, sdata_in, gpio_in, gpio_latch,
        input  sdata_out, gpio_out, gpio_in_s_insp
    );

    modport slave (
        input  saddress, swr, srd, sdata_in, gpio_in, gpio_latch,
        output sdata_out, gpio_out, gpio_in_s_insp
    );
endinterface

// File: rtl/gpio_mulpop.sv
// GPIO-emulator peripheral: sequential shift-add multiplier followed by a bit-serial
// popcount of the low product word, with status, result and operation-counter registers.
module gpio_mulpop #(
    parameter int          IN_W    = 24,
    parameter int          DATA_W  = 32,
    parameter int          CNT_W   = 16,
    parameter logic [31:0] ADDR_A1 = 32'h2C8,
    parameter logic [31:0] ADDR_A2 = 32'h2D0,
    parameter logic [31:0] ADDR_W  = 32'h2D8,
    parameter logic [31:0] ADDR_WH = 32'h2F0,
    parameter logic [31:0] ADDR_L  = 32'h2E0,
    parameter logic [31:0] ADDR_B  = 32'h2E8,
    parameter logic [31:0] ADDR_C  = 32'h2F8
) (
    input logic          clk,
    input logic          n_reset,
    gpio_mulpop_if.slave bus
);
    localparam int PW = 2 * IN_W;
    localparam int XW = 2 * DATA_W;
    localparam int SW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, MUL, POP, FIN} state_t;

    state_t            state_q;
    logic [IN_W-1:0]   a1_q;
    logic [IN_W-1:0]   mcd_q;
    logic [PW-1:0]     mpl_q;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     prod_q;
    logic [DATA_W-1:0] pop_q;
    logic [DATA_W-1:0] ones_q;
    logic [SW-1:0]     step_q;
    logic [SW-1:0]     ones_run_q;
    logic [CNT_W-1:0]  ops_q;
    logic [DATA_W-1:0] gpio_out_q;
    logic [DATA_W-1:0] insp_q;
    logic [DATA_W-1:0] sdata_out_q;
    logic              ovf_q, busy_q, bad_a1_q, bad_a2_q, done_q, rej_q;
    logic              latch_q;

    logic [PW-1:0]     acc_d;
    logic [DATA_W-1:0] acc_lo_d;
    logic [XW-1:0]     prod_x;
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] rd_d;
    logic              bad_in, hit_a1, hit_a2, latch_rise;

    always_comb begin
        acc_d      = mcd_q[0] ? acc_q + mpl_q : acc_q;
        acc_lo_d   = DATA_W'(acc_d);
        prod_x     = XW'(prod_q);
        bad_in     = (bus.sdata_in >> IN_W) != '0;
        hit_a1     = bus.saddress == ADDR_A1;
        hit_a2     = bus.saddress == ADDR_A2;
        latch_rise = bus.gpio_latch & ~latch_q;
        status      = '0;
        status[5:0] = {rej_q, done_q, bad_a2_q, bad_a1_q, busy_q, ovf_q};
        rd_d = '0;
        case (bus.saddress)
            ADDR_W:  rd_d = prod_x[DATA_W-1:0];
            ADDR_WH: rd_d = prod_x[XW-1:DATA_W];
            ADDR_L:  rd_d = ones_q;
            ADDR_B:  rd_d = status;
            ADDR_C:  rd_d = DATA_W'(ops_q);
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            a1_q        <= '0;
            mcd_q       <= '0;
            mpl_q       <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            pop_q       <= '0;
            ones_q      <= '0;
            step_q      <= '0;
            ones_run_q  <= '0;
            ops_q       <= '0;
            gpio_out_q  <= '0;
            insp_q      <= '0;
            sdata_out_q <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            bad_a1_q    <= 1'b0;
            bad_a2_q    <= 1'b0;
            done_q      <= 1'b0;
            rej_q       <= 1'b0;
            latch_q     <= 1'b0;
        end else begin
            latch_q <= bus.gpio_latch;
            // A read snapshots the counter into the inspection register and beats a latch edge
            if (bus.srd) begin
                sdata_out_q <= rd_d;
                insp_q      <= DATA_W'(ops_q);
            end else if (latch_rise) begin
                insp_q <= bus.gpio_in;
            end

            unique case (state_q)
                IDLE: ;
                MUL: begin
                    acc_q <= acc_d;
                    mpl_q <= mpl_q << 1;
                    mcd_q <= mcd_q >> 1;
                    if (step_q == SW'(IN_W - 1)) begin
                        step_q     <= '0;
                        pop_q      <= acc_lo_d;
                        ones_run_q <= '0;
                        state_q    <= POP;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                POP: begin
                    ones_run_q <= ones_run_q + SW'(pop_q[0]);
                    pop_q      <= pop_q >> 1;
                    if (step_q == SW'(DATA_W - 1)) begin
                        step_q  <= '0;
                        state_q <= FIN;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                FIN: begin
                    prod_q  <= acc_q;
                    ones_q  <= DATA_W'(ones_run_q);
                    ovf_q   <= (XW'(acc_q) >> DATA_W) != '0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    ops_q   <= ops_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Operand writes only act in IDLE, so they never collide with the FSM updates above
            if (bus.swr) begin
                if (hit_a1 || hit_a2) begin
                    if (busy_q) begin
                        rej_q <= 1'b1;
                    end else begin
                        done_q <= 1'b0;
                        ovf_q  <= 1'b0;
                        rej_q  <= 1'b0;
                        if (hit_a1) begin
                            if (bad_in) begin
                                bad_a1_q <= 1'b1;
                            end else begin
                                a1_q     <= bus.sdata_in[IN_W-1:0];
                                bad_a1_q <= 1'b0;
                            end
                        end else if (bad_in) begin
                            bad_a2_q <= 1'b1;
                        end else begin
                            bad_a2_q <= 1'b0;
                            mcd_q    <= bus.sdata_in[IN_W-1:0];
                            if (!bad_a1_q) begin
                                busy_q  <= 1'b1;
                                state_q <= MUL;
                                step_q  <= '0;
                                acc_q   <= '0;
                                mpl_q   <= PW'(a1_q);
                            end
                        end
                    end
                end else begin
                    gpio_out_q <= bus.sdata_in;
                end
            end
        end
    end

    assign bus.sdata_out      = sdata_out_q;
    assign bus.gpio_out       = gpio_out_q;
    assign bus.gpio_in_s_insp = insp_q;
endmodule

// File: tb/tb_gpio_mulpop.sv
// Directed bench for gpio_mulpop: transaction-level reference model compared every cycle,
// plus literal expectations for the documented scenarios.
module tb_gpio_mulpop;
    localparam logic [31:0] A_A1 = 32'h2C8;
    localparam logic [31:0] A_A2 = 32'h2D0;
    localparam logic [31:0] A_W  = 32'h2D8;
    localparam logic [31:0] A_WH = 32'h2F0;
    localparam logic [31:0] A_L  = 32'h2E0;
    localparam logic [31:0] A_B  = 32'h2E8;
    localparam logic [31:0] A_C  = 32'h2F8;
    localparam int TOTAL = 24 + 32 + 1;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] s;

    gpio_mulpop_if #(.DATA_W(32)) bus ();

    gpio_mulpop #(.IN_W(24), .DATA_W(32), .CNT_W(4)) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    // Reference model: whole-operation view with a completion countdown
    logic [23:0] m_a1, m_a2, m_pa1, m_pa2;
    logic        m_bad1, m_bad2, m_busy, m_done, m_ovf, m_rej, m_lprev;
    int          m_timer;
    logic [31:0] m_W, m_WH, m_L, m_gout, m_insp, m_sdo;
    logic [3:0]  m_cnt;

    function automatic logic [63:0] pmul(input logic [23:0] a, input logic [23:0] b);
        return {40'd0, a} * {40'd0, b};
    endfunction
    function automatic logic [31:0] plo(input logic [23:0] a, input logic [23:0] b);
        return 32'(pmul(a, b));
    endfunction
    function automatic logic [31:0] phi(input logic [23:0] a, input logic [23:0] b);
        return 32'(pmul(a, b) >> 32);
    endfunction
    function automatic logic [31:0] mread(input logic [31:0] a);
        case (a)
            A_W:     return m_W;
            A_WH:    return m_WH;
            A_L:     return m_L;
            A_B:     return {26'd0, m_rej, m_done, m_bad2, m_bad1, m_busy, m_ovf};
            A_C:     return 32'(m_cnt);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_a1 <= '0; m_a2 <= '0; m_pa1 <= '0; m_pa2 <= '0;
            m_bad1 <= 0; m_bad2 <= 0; m_busy <= 0; m_done <= 0; m_ovf <= 0; m_rej <= 0;
            m_lprev <= 0; m_timer <= 0;
            m_W <= '0; m_WH <= '0; m_L <= '0; m_gout <= '0; m_insp <= '0; m_sdo <= '0;
            m_cnt <= '0;
        end else begin
            if (bus.srd) begin
                m_sdo  <= mread(bus.saddress);
                m_insp <= 32'(m_cnt);
            end else if (bus.gpio_latch && !m_lprev) begin
                m_insp <= bus.gpio_in;
            end
            m_lprev <= bus.gpio_latch;
            if (m_busy) begin
                if (m_timer == 1) begin
                    m_W    <= plo(m_pa1, m_pa2);
                    m_WH   <= phi(m_pa1, m_pa2);
                    m_L    <= 32'($countones(plo(m_pa1, m_pa2)));
                    m_ovf  <= phi(m_pa1, m_pa2) != 0;
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                    m_cnt  <= m_cnt + 4'd1;
                end else begin
                    m_timer <= m_timer - 1;
                end
            end
            if (bus.swr) begin
                if (bus.saddress == A_A1 || bus.saddress == A_A2) begin
                    if (m_busy) begin
                        m_rej <= 1'b1;
                    end else begin
                        m_done <= 0; m_ovf <= 0; m_rej <= 0;
                        if (bus.saddress == A_A1) begin
                            if (bus.sdata_in > 32'hFFFFFF) m_bad1 <= 1'b1;
                            else begin m_a1 <= bus.sdata_in[23:0]; m_bad1 <= 1'b0; end
                        end else if (bus.sdata_in > 32'hFFFFFF) begin
                            m_bad2 <= 1'b1;
                        end else begin
                            m_a2 <= bus.sdata_in[23:0];
                            m_bad2 <= 1'b0;
                            if (!m_bad1) begin
                                m_busy  <= 1'b1;
                                m_timer <= TOTAL;
                                m_pa1   <= m_a1;
                                m_pa2   <= bus.sdata_in[23:0];
                            end
                        end
                    end
                end else begin
                    m_gout <= bus.sdata_in;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (n_reset) begin
            check("sdata_out", bus.sdata_out, m_sdo);
            check("gpio_out", bus.gpio_out, m_gout);
            check("gpio_in_s_insp", bus.gpio_in_s_insp, m_insp);
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.saddress = a; bus.sdata_in = d; bus.swr = 1'b1;
        @(negedge clk);
        bus.swr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.saddress = a; bus.srd = 1'b1;
        @(negedge clk);
        bus.srd = 1'b0;
        d = bus.sdata_out;
    endtask

    task automatic wait_done();
        logic [31:0] st;
        bit got;
        got = 1'b0;
        for (int i = 0; i < 120 && !got; i++) begin
            rd(A_B, st);
            got = st[4];
        end
        if (!got) check("wait_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.saddress = '0; bus.swr = 0; bus.srd = 0; bus.sdata_in = '0;
        bus.gpio_in = '0; bus.gpio_latch = 0;
        repeat (3) @(negedge clk);
        check("rst_sdata_out", bus.sdata_out, 32'd0);
        check("rst_gpio_out", bus.gpio_out, 32'd0);
        check("rst_insp", bus.gpio_in_s_insp, 32'd0);
        n_reset = 1'b1;
        @(negedge clk);

        // 3 x 5; status is read every cycle through the commit edge
        wr(A_A1, 32'd3);
        wr(A_A2, 32'd5);
        for (int i = 0; i < TOTAL; i++) begin
            rd(A_B, s);
            check("busy_poll", s & 32'h13, 32'h02);
        end
        rd(A_B, s);  check("basic_B", s, 32'h10);
        rd(A_W, s);  check("basic_W", s, 32'd15);
        rd(A_WH, s); check("basic_WH", s, 32'd0);
        rd(A_L, s);  check("basic_L", s, 32'd4);
        rd(A_C, s);  check("basic_C", s, 32'd1);

        wr(A_A1, 32'hFFFFFF);
        wr(A_A2, 32'hFFFFFF);
        wait_done();
        rd(A_W, s);  check("ovf_W", s, 32'hFE000001);
        rd(A_WH, s); check("ovf_WH", s, 32'hFFFF);
        rd(A_L, s);  check("ovf_L", s, 32'd8);
        rd(A_B, s);  check("ovf_B", s, 32'h11);

        wr(A_A1, 32'h1000000);
        rd(A_B, s);  check("bad_a1_B", s, 32'h04);
        wr(A_A2, 32'd2);
        rd(A_B, s);  check("bad_a1_nostart_B", s, 32'h04);
        repeat (3) @(negedge clk);
        rd(A_C, s);  check("bad_a1_C", s, 32'd2);

        // 7 x 9 with a rejected A1 write ten cycles in
        wr(A_A1, 32'd7);
        wr(A_A2, 32'd9);
        repeat (9) @(negedge clk);
        wr(A_A1, 32'd100);
        rd(A_B, s);  check("rej_B", s, 32'h22);
        wait_done();
        rd(A_B, s);  check("rej_done_B", s, 32'h30);
        rd(A_W, s);  check("rej_W", s, 32'd63);
        wr(A_A2, 32'd1);
        wait_done();
        rd(A_W, s);  check("a1_kept_W", s, 32'd7);

        wr(32'h100, 32'hA5);
        check("gpio_out_A5", bus.gpio_out, 32'hA5);
        bus.gpio_in = 32'h1234;
        bus.gpio_latch = 1'b1;
        @(negedge clk);
        check("latch_insp", bus.gpio_in_s_insp, 32'h1234);
        rd(32'h100, s);
        check("other_rd", s, 32'd0);
        check("rd_insp_cnt", bus.gpio_in_s_insp, 32'd4);
        bus.gpio_latch = 1'b0;

        rd(A_C, s);  check("pre_rst_C", s, 32'd4);
        wr(A_A1, 32'd5);
        wr(A_A2, 32'd6);
        repeat (19) @(negedge clk);
        n_reset = 1'b0;
        #1;
        check("midrst_sdata_out", bus.sdata_out, 32'd0);
        check("midrst_gpio_out", bus.gpio_out, 32'd0);
        check("midrst_insp", bus.gpio_in_s_insp, 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        rd(A_B, s);  check("midrst_B", s, 32'd0);
        rd(A_C, s);  check("midrst_C", s, 32'd0);
        wr(A_A1, 32'd2);
        wr(A_A2, 32'd2);
        wait_done();
        rd(A_W, s);  check("post_rst_W", s, 32'd4);
        rd(A_C, s);  check("post_rst_C", s, 32'd1);

        // Fifteen more operations take the 4-bit counter from 1 round to 0
        for (int k = 0; k < 15; k++) begin
            wr(A_A1, 32'(k + 3));
            wr(A_A2, 32'(k * 1000 + 11));
            wait_done();
            rd(A_W, s);
        end
        check("wrap_last_W", s, 32'h3A26B);
        rd(A_C, s);  check("wrap_C", s, 32'd0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
